// File: rtl/dds_pkg.sv
// Shared DDS constants and types, reused by the sweep controller, this phase
// engine and the waveform LUT stage.
package dds_pkg;

    localparam int unsigned CLK_HZ      = 100_000_000;
    localparam int          ACC_W       = 32;
    localparam int          PHASE_OUT_W = 12;
    localparam int          FREQ_W      = 20;
    localparam int          PROD_W      = 42;
    localparam int          K_SHIFT     = 16;

    // round(2^48 / CLK_HZ); the 2^48 scale keeps 16 fractional bits until the
    // final shift so the tuning word rounds toward zero only once.
    localparam logic [21:0] K_MULT      = 22'd2814750;

    // Dither LFSR: x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form.
    localparam int          LFSR_W      = 16;
    localparam logic [15:0] LFSR_SEED   = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        PEND  = 2'd2,
        APPLY = 2'd3
    } dds_state_e;

    // Scale the Hz*K_MULT product down to an ACC_W tuning word.
    function automatic logic [ACC_W-1:0] prod_to_word(input logic [PROD_W-1:0] prod);
        logic [K_SHIFT+ACC_W-1:0] ext;
        ext = {{(K_SHIFT + ACC_W - PROD_W){1'b0}}, prod};
        return ext[K_SHIFT +: ACC_W];
    endfunction

endpackage

// File: rtl/dds_phase_engine_freq_mult_seq.sv
// Sequential shift-add multiplier: operand (Hz) * K_MULT, one operand bit per
// clock, LSB first. product and done are combinational views of the final
// iteration so the parent can capture the result on the same edge.
module freq_mult_seq
    import dds_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [FREQ_W-1:0] operand,
    output logic              done,
    output logic [PROD_W-1:0] product
);

    logic [FREQ_W-1:0] op_q,   op_d;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic [4:0]        idx_q,  idx_d;
    logic              run_q,  run_d;

    // Next-state: load on start, otherwise accumulate one partial product per cycle.
    always_comb begin
        op_d   = op_q;
        prod_d = prod_q;
        idx_d  = idx_q;
        run_d  = run_q;
        done   = 1'b0;
        if (start) begin
            op_d   = operand;
            prod_d = '0;
            idx_d  = '0;
            run_d  = 1'b1;
        end else if (run_q) begin
            if (op_q[idx_q]) begin
                prod_d = prod_q + (PROD_W'(K_MULT) << idx_q);
            end
            if (idx_q == 5'(FREQ_W - 1)) begin
                run_d = 1'b0;
                done  = 1'b1;
            end else begin
                idx_d = idx_q + 5'd1;
            end
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= '0;
            prod_q <= '0;
            idx_q  <= '0;
            run_q  <= 1'b0;
        end else begin
            op_q   <= op_d;
            prod_q <= prod_d;
            idx_q  <= idx_d;
            run_q  <= run_d;
        end
    end

    assign product = prod_d;

endmodule

// File: rtl/dds_phase_engine.sv
// DDS phase engine: tracks freq_in, converts it to a tuning word and applies
// it glitch-free to the phase accumulator feeding the waveform LUT.
// Optional build macro: PHASE_DITHER_EN adds LFSR dither ahead of the
// phase_out truncation (accumulator itself stays undithered).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | compare freq_in with the latched value, start a conversion
// CALC  | multiplier running (busy), 20 cycles
// PEND  | word ready, waiting for an accumulator wrap to load it
// APPLY | cycle in which a completion-time word has just been loaded
module dds_phase_engine
    import dds_pkg::*;
#(
    parameter bit UPDATE_ON_WRAP = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [FREQ_W-1:0]      freq_in,
    output logic [PHASE_OUT_W-1:0] phase_out,
    output logic [ACC_W-1:0]       phase_inc,
    output logic                   busy,
    output logic                   inc_upd,
    output logic                   wrap
);

    localparam int LOW_W     = ACC_W - PHASE_OUT_W;
    localparam int LOW_SUM_W = LOW_W + 1;

    dds_state_e             state_q, state_d;
    logic [FREQ_W-1:0]      freq_lat_q, freq_lat_d;
    logic [ACC_W-1:0]       result_q, result_d;
    logic [ACC_W-1:0]       phase_inc_q, phase_inc_d;
    logic                   inc_upd_q, inc_upd_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic                   wrap_q, wrap_d;
    logic [PHASE_OUT_W-1:0] phase_out_q, phase_out_d;
    logic [ACC_W:0]         acc_sum;
    logic                   mult_start;
    logic                   mult_done;
    logic [PROD_W-1:0]      mult_product;
    logic [ACC_W-1:0]       new_word;
    logic                   load_ok;

    freq_mult_seq u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (mult_start),
        .operand (freq_in),
        .done    (mult_done),
        .product (mult_product)
    );

    // Phase accumulator add; carry-out becomes the wrap pulse.
    always_comb begin
        acc_sum = {1'b0, acc_q} + {1'b0, phase_inc_q};
        acc_d   = acc_q;
        wrap_d  = 1'b0;
        if (enable) begin
            acc_d  = acc_sum[ACC_W-1:0];
            wrap_d = acc_sum[ACC_W];
        end
    end

    // Next-state and word-load decisions for the conversion FSM.
    always_comb begin
        state_d     = state_q;
        freq_lat_d  = freq_lat_q;
        result_d    = result_q;
        phase_inc_d = phase_inc_q;
        inc_upd_d   = 1'b0;
        mult_start  = 1'b0;
        new_word    = prod_to_word(mult_product);
        // A zero word never wraps, so there is no phase continuity to protect;
        // loading at once avoids waiting forever when starting from rest.
        load_ok     = wrap_d || (phase_inc_q == '0);
        unique case (state_q)
            IDLE: begin
                if (freq_in != freq_lat_q) begin
                    freq_lat_d = freq_in;
                    mult_start = 1'b1;
                    state_d    = CALC;
                end
            end
            CALC: begin
                if (mult_done) begin
                    result_d = new_word;
                    if (!UPDATE_ON_WRAP) begin
                        phase_inc_d = new_word;
                        inc_upd_d   = 1'b1;
                        state_d     = APPLY;
                    end else if (load_ok) begin
                        phase_inc_d = new_word;
                        inc_upd_d   = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
                if (load_ok) begin
                    phase_inc_d = result_q;
                    inc_upd_d   = 1'b1;
                    state_d     = IDLE;
                end
            end
            APPLY: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef PHASE_DITHER_EN
    logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
    logic [LOW_SUM_W-1:0] low_sum;

    // Dither LFSR advance and dithered MSB extraction.
    always_comb begin
        lfsr_d = lfsr_q;
        if (enable) begin
            lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        end
        low_sum     = {1'b0, acc_d[LOW_W-1:0]} + LOW_SUM_W'(lfsr_q[LOW_W-5:0]);
        phase_out_d = acc_d[ACC_W-1 -: PHASE_OUT_W] + PHASE_OUT_W'(low_sum[LOW_W]);
    end

    // Dither LFSR register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    // Plain MSB extraction of the next accumulator value.
    always_comb begin
        phase_out_d = acc_d[ACC_W-1 -: PHASE_OUT_W];
    end
`endif

    // FSM, tuning word and accumulator registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            freq_lat_q  <= '0;
            result_q    <= '0;
            phase_inc_q <= '0;
            inc_upd_q   <= 1'b0;
            acc_q       <= '0;
            wrap_q      <= 1'b0;
            phase_out_q <= '0;
        end else begin
            state_q     <= state_d;
            freq_lat_q  <= freq_lat_d;
            result_q    <= result_d;
            phase_inc_q <= phase_inc_d;
            inc_upd_q   <= inc_upd_d;
            acc_q       <= acc_d;
            wrap_q      <= wrap_d;
            phase_out_q <= phase_out_d;
        end
    end

    assign phase_out = phase_out_q;
    assign phase_inc = phase_inc_q;
    assign busy      = (state_q == CALC);
    assign inc_upd   = inc_upd_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_dds_phase_engine.sv
// Bench for dds_phase_engine: one instance loading words on completion, one
// loading on wrap; a cycle model of the completion-time instance is checked
// every cycle.
module tb_dds_phase_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [19:0] freq_a = '0;
    logic [19:0] freq_b = '0;

    logic [11:0] po_a, po_b;
    logic [31:0] inc_a, inc_b;
    logic        busy_a, busy_b, upd_a, upd_b, wrap_a, wrap_b;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    dds_phase_engine #(.UPDATE_ON_WRAP(1'b0)) u_now (
        .clk(clk), .rst(rst), .enable(enable), .freq_in(freq_a),
        .phase_out(po_a), .phase_inc(inc_a), .busy(busy_a),
        .inc_upd(upd_a), .wrap(wrap_a)
    );

    dds_phase_engine #(.UPDATE_ON_WRAP(1'b1)) u_wrap (
        .clk(clk), .rst(rst), .enable(enable), .freq_in(freq_b),
        .phase_out(po_b), .phase_inc(inc_b), .busy(busy_b),
        .inc_upd(upd_b), .wrap(wrap_b)
    );

    // Hz -> tuning word at 100 MHz: floor(f * 2814750 / 2^16).
    function automatic logic [31:0] word_of(input logic [19:0] f);
        longint unsigned p;
        p = longint'(f) * 64'd2814750;
        return 32'(p >> 16);
    endfunction

    // Reference model of the completion-time instance.
    logic [19:0] m_lat;
    int          m_cnt;
    bit          m_hold;
    logic [31:0] m_inc, m_acc;
    logic        m_wrap, m_upd;
    logic [32:0] m_sum;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lat = '0; m_cnt = 0; m_hold = 0; m_inc = '0; m_acc = '0;
            m_wrap = 0; m_upd = 0;
        end else begin
            m_upd = 0;
            if (enable) begin
                m_sum  = {1'b0, m_acc} + {1'b0, m_inc};
                m_acc  = m_sum[31:0];
                m_wrap = m_sum[32];
            end else begin
                m_wrap = 0;
            end
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_inc  = word_of(m_lat);
                    m_upd  = 1;
                    m_hold = 1;
                end
            end else if (m_hold) begin
                m_hold = 0;
            end else if (freq_a != m_lat) begin
                m_lat = freq_a;
                m_cnt = 20;
            end
        end
    end

    logic [31:0] loaded[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cmp_u0();
        logic [11:0] d;
        chk("now_phase_inc", inc_a, m_inc);
        chk("now_busy", busy_a, m_cnt > 0);
        chk("now_inc_upd", upd_a, m_upd);
        chk("now_wrap", wrap_a, m_wrap);
`ifdef PHASE_DITHER_EN
        d = po_a - m_acc[31:20];
        chk("now_phase_out_dither", d <= 12'd1, 1'b1);
`else
        d = m_acc[31:20];
        chk("now_phase_out", po_a, d);
`endif
        if (upd_a) loaded.push_back(inc_a);
    endtask

    task automatic cyc();
        @(negedge clk);
        cmp_u0();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        int          bn;
        bit          seen;
        logic [11:0] hold_po;
        logic [19:0] f;

        // Reset values on both instances.
        @(negedge clk);
        chk("rst_po_a", po_a, 0);   chk("rst_inc_a", inc_a, 0);
        chk("rst_busy_a", busy_a, 0); chk("rst_upd_a", upd_a, 0);
        chk("rst_wrap_a", wrap_a, 0);
        chk("rst_po_b", po_b, 0);   chk("rst_inc_b", inc_b, 0);
        chk("rst_busy_b", busy_b, 0); chk("rst_upd_b", upd_b, 0);
        chk("rst_wrap_b", wrap_b, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        enable = 1'b1;

        // 100 kHz on the completion-time instance: 20 busy cycles.
        freq_a = 20'd100000;
        bn = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy_a) bn++;
            cmp_u0();
            @(posedge clk); #1;
        end
        chk("t1_busy_cycles", bn, 20);
        chk("t1_word", inc_a, 32'd4294967);

        // Wrap-synchronised instance: start from rest, then step 100k -> 200k.
        freq_b = 20'd100000;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (upd_b) seen = 1;
            cmp_u0();
            @(posedge clk); #1;
        end
        chk("t3_start_seen", seen, 1);
        chk("t3_start_word", inc_b, word_of(20'd100000));
        freq_b = 20'd200000;
        bn = 0;
        seen = 0;
        for (int i = 0; i < 2500 && !seen; i++) begin
            @(negedge clk);
            if (busy_b) bn++;
            if (upd_b) begin
                seen = 1;
                chk("t3_upd_with_wrap", wrap_b, 1);
                chk("t3_busy_cycles", bn, 20);
                chk("t3_upd_not_busy", busy_b, 0);
            end else if (bn > 0 && !busy_b) begin
                chk("t3_old_word_held", inc_b, word_of(20'd100000));
            end
            cmp_u0();
            @(posedge clk); #1;
        end
        chk("t3_upd_seen", seen, 1);
        chk("t3_word", inc_b, word_of(20'd200000));

        // Spot frequencies, including zero.
        freq_a = 20'd1000;   run(25); chk("t2_1000", inc_a, 32'd42949);
        freq_a = 20'd999000; run(25); chk("t2_999000", inc_a, 32'd42906726);
        freq_a = 20'd0;      run(25); chk("t2_zero", inc_a, 32'd0);
        hold_po = po_a;
        run(10);
`ifndef PHASE_DITHER_EN
        chk("t2_acc_holds", po_a, hold_po);
`endif

        // Conversion proceeds with enable low; accumulator frozen meanwhile.
        enable = 1'b0;
        freq_a = 20'd1000;
        run(25);
        chk("en0_word", inc_a, 32'd42949);
        chk("en0_wrap", wrap_a, 0);
        enable = 1'b1;
        run(5);

        // Changes during CALC: last value wins, no intermediate word.
        freq_a = 20'd2000; run(25);
        loaded.delete();
        freq_a = 20'd1000; run(5);
        freq_a = 20'd5000; run(5);
        freq_a = 20'd7000; run(60);
        chk("t4_loads", loaded.size(), 2);
        if (loaded.size() == 2) begin
            chk("t4_first", loaded[0], 32'd42949);
            chk("t4_second", loaded[1], 32'd300647);
        end
        foreach (loaded[k]) chk("t4_no_5000", loaded[k] == word_of(20'd5000), 0);
        chk("t4_final", inc_a, 32'd300647);

        // Reset at the 10th CALC cycle aborts the conversion.
        freq_a = 20'd3000;
        bn = 0;
        for (int i = 0; i < 15 && bn < 10; i++) begin
            @(negedge clk);
            if (busy_a) bn++;
            cmp_u0();
            @(posedge clk); #1;
        end
        chk("t5_reached_calc10", bn, 10);
        loaded.delete();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_po", po_a, 0);     chk("t5_inc", inc_a, 0);
        chk("t5_busy", busy_a, 0); chk("t5_upd", upd_a, 0);
        chk("t5_wrap", wrap_a, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run(30);
        chk("t5_reload_count", loaded.size(), 1);
        chk("t5_reconvert", inc_a, word_of(20'd3000));

        // Random frequencies and enable patterns against the model.
        for (int r = 0; r < 8; r++) begin
            f = 20'($urandom_range(0, 1048575));
            enable = 1'($urandom_range(0, 1));
            freq_a = f;
            run(25 + $urandom_range(0, 20));
            chk("rand_word", inc_a, word_of(f));
        end
        enable = 1'b1;
        run(50);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
